// File: rtl/tri_feeder.sv
// Double-buffered triangle feeder for vertex_calc: assembles 15-word triangles from a
// word stream and presents each one on a bus that stays frozen until the consumer releases it.
module tri_feeder #(
    parameter int WORDS_PER_TRI = 15,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [14:0][31:0] v_out,
    output logic [23:0]       color_out1,
    output logic [23:0]       color_out2,
    output logic [23:0]       color_out3,
    output logic              out_data_valid,
    output logic              done_out,
    input  logic              stall_in,
    output logic [15:0]       tri_count,
    output logic              err_frame,
    output logic              err_timeout,
    output logic [1:0]        dbg_state
);

    // Input side: a word moves on a rising edge with in_valid && in_ready; in_ready depends
    // only on registers. Output side: out_data_valid rises with the bus loaded, the consumer
    // raises stall_in, and the bus is released only after stall_in falls again.
    localparam logic [3:0]  LAST_IDX = 4'(WORDS_PER_TRI - 1);
    localparam logic [31:0] TMO      = 32'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        P_IDLE     = 2'd0,
        P_WAIT_ACC = 2'd1,
        P_WAIT_REL = 2'd2
    } p_state_e;

    logic [14:0][31:0] r_slot [2];
    logic [1:0]        r_full;
    logic [1:0]        r_done;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [3:0]        r_idx;
    logic              r_err_frame;
    logic              r_err_timeout;
    logic [31:0]       r_timer;
    p_state_e          r_state;
    p_state_e          w_state_nxt;
    logic              w_load;
    logic              w_release;
    logic              w_accept;
    logic              w_tri_done;
    logic              w_short;

    logic [14:0][31:0] r_v_out;
    logic [23:0]       r_color1;
    logic [23:0]       r_color2;
    logic [23:0]       r_color3;
    logic              r_valid;
    logic              r_done_out;
    logic [15:0]       r_tri_count;

    assign in_ready   = !r_full[r_wr_ptr];
    assign w_accept   = in_valid && in_ready;
    assign w_tri_done = w_accept && (r_idx == LAST_IDX);
    assign w_short    = w_accept && in_last && (r_idx != LAST_IDX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idx       <= 4'd0;
            r_wr_ptr    <= 1'b0;
            r_err_frame <= 1'b0;
        end else if (w_accept) begin
            if (w_tri_done) begin
                r_idx    <= 4'd0;
                r_wr_ptr <= ~r_wr_ptr;
            end else if (in_last) begin
                r_idx       <= 4'd0;
                r_err_frame <= 1'b1;
            end else begin
                r_idx <= r_idx + 4'd1;
            end
        end
    end

    // Storage needs no reset: a slot is only read after all 15 words were written.
    always_ff @(posedge clock) begin
        if (w_accept && !w_short) begin
            r_slot[r_wr_ptr][r_idx] <= in_data;
        end
    end

    // Fill and release always target different slots, so both updates can land together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_full <= 2'b00;
            r_done <= 2'b00;
        end else begin
            if (w_release) begin
                r_full[r_rd_ptr] <= 1'b0;
            end
            if (w_tri_done) begin
                r_full[r_wr_ptr] <= 1'b1;
                r_done[r_wr_ptr] <= in_last;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            P_IDLE: begin
                if (r_full[r_rd_ptr]) begin
                    w_load      = 1'b1;
                    w_state_nxt = P_WAIT_ACC;
                end
            end
            P_WAIT_ACC: begin
                if (stall_in) begin
                    w_state_nxt = P_WAIT_REL;
                end
            end
            P_WAIT_REL: begin
                if (!stall_in) begin
                    w_release   = 1'b1;
                    w_state_nxt = P_IDLE;
                end
            end
            default: w_state_nxt = P_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= P_IDLE;
            r_rd_ptr    <= 1'b0;
            r_v_out     <= '0;
            r_color1    <= 24'd0;
            r_color2    <= 24'd0;
            r_color3    <= 24'd0;
            r_valid     <= 1'b0;
            r_done_out  <= 1'b0;
            r_tri_count <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_v_out    <= r_slot[r_rd_ptr];
                r_color1   <= r_slot[r_rd_ptr][3][23:0];
                r_color2   <= r_slot[r_rd_ptr][7][23:0];
                r_color3   <= r_slot[r_rd_ptr][11][23:0];
                r_done_out <= r_done[r_rd_ptr];
                r_valid    <= 1'b1;
            end
            // v_out and colors deliberately keep the released triangle until the next load.
            if (w_release) begin
                r_valid     <= 1'b0;
                r_done_out  <= 1'b0;
                r_rd_ptr    <= ~r_rd_ptr;
                r_tri_count <= r_tri_count + 16'd1;
            end
        end
    end

    // Wait-state timer restarts on every state change and saturates; the error is sticky.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timer       <= 32'd0;
            r_err_timeout <= 1'b0;
        end else if (r_state == P_IDLE || w_state_nxt != r_state) begin
            r_timer <= 32'd0;
        end else if (r_timer != TMO) begin
            r_timer <= r_timer + 32'd1;
            if (TIMEOUT_CYC != 0 && (r_timer + 32'd1) == TMO) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign v_out          = r_v_out;
    assign color_out1     = r_color1;
    assign color_out2     = r_color2;
    assign color_out3     = r_color3;
    assign out_data_valid = r_valid;
    assign done_out       = r_done_out;
    assign tri_count      = r_tri_count;
    assign err_frame      = r_err_frame;
    assign err_timeout    = r_err_timeout;
    assign dbg_state      = r_state;

endmodule
